// File: rtl/xpmwrap_sdpram_reader.sv
// Read-side controller for the simple dual-port RAM wrapper: (addr, len) command in, valid/ready stream out.
// Latency: command at T gives enb at T+1 and first beat at T+2+READ_LATENCY_B; backpressure is absorbed by a credit-limited FWFT FIFO.

// Generic first-word-fall-through FIFO, power-of-two depth.
// Latency: a push is visible at the head the next cycle.
// Backpressure: pop only when pop_rdy; the producer must never push while full.
module xpmwrap_sdpram_reader_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         pop_vld,
  output logic [W-1:0] pop_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         empty, full, pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = pop_rdy && !empty;
  assign pop_vld = !empty;
  assign pop_dat = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + (AW+1)'(push_vld);
    rd_d = rd_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      assert (!(push_vld && full));
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) mem_q[wr_q[AW-1:0]] <= push_dat;
  end
endmodule

// Issues one RAM read per cycle while credit allows, tags each read through a latency pipe,
// and lands the returning words in the output FIFO; m_ready feeds ram_enb combinationally
// so a freed slot is reused the same cycle.
module xpmwrap_sdpram_reader #(
  parameter int ADDR_WIDTH_B      = 6,
  parameter int READ_DATA_WIDTH_B = 32,
  parameter int READ_LATENCY_B    = 2,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                         clkb,
  input  logic                         rstb_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [ADDR_WIDTH_B-1:0]      cmd_addr,
  input  logic [ADDR_WIDTH_B:0]        cmd_len,
  output logic [ADDR_WIDTH_B-1:0]      ram_addrb,
  output logic                         ram_enb,
  output logic                         ram_regceb,
  input  logic [READ_DATA_WIDTH_B-1:0] ram_doutb,
  output logic [READ_DATA_WIDTH_B-1:0] m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic                         busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int RW = ADDR_WIDTH_B + 1;
  localparam int L  = READ_LATENCY_B;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH_B-1:0] addr_q, addr_d;
  logic [RW-1:0]           rem_q, rem_d;
  logic [CW-1:0]           credit_q, credit_d;
  logic [L-1:0]            tag_vld_q, tag_vld_d, tag_last_q, tag_last_d;
  logic                    cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic                    pop, issue, cmd_fire, fifo_vld;
  logic [READ_DATA_WIDTH_B:0] fifo_dat;

  assign pop      = fifo_vld && m_ready;
  assign cmd_fire = cmd_valid && cmd_ready_q;
  // credit covers words in the tag pipe plus the FIFO, so it can never overrun the FIFO
  assign issue    = (state_q == ISSUE) && ((credit_q - CW'(pop)) < CW'(FIFO_DEPTH));

  assign ram_enb    = issue;
  assign ram_addrb  = addr_q;
  assign ram_regceb = 1'b1;
  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign m_valid    = fifo_vld;
  assign {m_last, m_data} = fifo_dat;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    credit_d   = credit_q + CW'(issue) - CW'(pop);
    tag_vld_d  = (tag_vld_q << 1) | L'(issue);
    tag_last_d = (tag_last_q << 1) | L'(issue && (rem_q == RW'(1)));
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          addr_d = cmd_addr;
          rem_d  = cmd_len;
          if (cmd_len != '0) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d = addr_q + ADDR_WIDTH_B'(1);
          rem_d  = rem_q - RW'(1);
          if (rem_q == RW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (credit_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      credit_q    <= '0;
      tag_vld_q   <= '0;
      tag_last_q  <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      credit_q    <= credit_d;
      tag_vld_q   <= tag_vld_d;
      tag_last_q  <= tag_last_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  xpmwrap_sdpram_reader_fifo #(
    .W     (READ_DATA_WIDTH_B + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clkb),
    .rst_n    (rstb_n),
    .push_vld (tag_vld_q[L-1]),
    .push_dat ({tag_last_q[L-1], ram_doutb}),
    .pop_rdy  (m_ready),
    .pop_vld  (fifo_vld),
    .pop_dat  (fifo_dat)
  );
endmodule

// File: tb/tb_xpmwrap_sdpram_reader.sv
// Bench for xpmwrap_sdpram_reader: behavioural 2-cycle RAM, address and beat scoreboards, directed commands.
module tb_xpmwrap_sdpram_reader;
  logic        clkb = 1'b0;
  logic        rstb_n;
  logic        cmd_valid, cmd_ready;
  logic [5:0]  cmd_addr;
  logic [6:0]  cmd_len;
  logic [5:0]  ram_addrb;
  logic        ram_enb, ram_regceb;
  logic [31:0] ram_doutb;
  logic [31:0] m_data;
  logic        m_valid, m_ready, m_last, busy;

  always #5 clkb = ~clkb;

  xpmwrap_sdpram_reader #(
    .ADDR_WIDTH_B(6), .READ_DATA_WIDTH_B(32), .READ_LATENCY_B(2), .FIFO_DEPTH(4)
  ) dut (
    .clkb(clkb), .rstb_n(rstb_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_regceb(ram_regceb), .ram_doutb(ram_doutb),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy)
  );

  function automatic logic [31:0] mem_word(input logic [5:0] a);
    return 32'hBEEF_0000 | {26'd0, a};
  endfunction

  // RAM port B: enb-gated read register followed by the regceb-gated output register
  logic [31:0] ram [64];
  logic [31:0] r1, r2;
  initial for (int i = 0; i < 64; i++) ram[i] = mem_word(6'(i));
  always @(posedge clkb) begin
    if (ram_enb) r1 <= ram[ram_addrb];
    if (ram_regceb) r2 <= r1;
  end
  assign ram_doutb = r2;

  int total = 0;
  int bad   = 0;
  int enb_cnt = 0, beat_cnt = 0, last_cnt = 0;
  logic [5:0]  exp_addr_q [$];
  logic [32:0] exp_beat_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic        prev_stall = 1'b0;
  logic [32:0] prev_beat  = '0;
  logic [32:0] exp_beat;
  logic [5:0]  exp_addr;

  always @(negedge clkb) begin
    if (!rstb_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_hold", {m_last, m_data}, prev_beat);
      end
      if (ram_enb) begin
        enb_cnt++;
        if (exp_addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_enb: addrb=%0d with nothing expected", ram_addrb);
        end else begin
          exp_addr = exp_addr_q.pop_front();
          chk("ram_addrb", ram_addrb, exp_addr);
        end
      end
      if (m_valid && m_ready) begin
        beat_cnt++;
        if (m_last) last_cnt++;
        if (exp_beat_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: data=%0h last=%0b", m_data, m_last);
        end else begin
          exp_beat = exp_beat_q.pop_front();
          chk("beat", {m_last, m_data}, exp_beat);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_beat  = {m_last, m_data};
    end
  end

  task automatic send_cmd(input logic [5:0] a, input int n);
    int k = 0;
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(a + 6'(i));
      exp_beat_q.push_back({(i == n - 1), mem_word(a + 6'(i))});
    end
    cmd_addr  = a;
    cmd_len   = 7'(n);
    cmd_valid = 1'b1;
    while (!cmd_ready && k < 50) begin
      @(posedge clkb); #1;
      k++;
    end
    chk("cmd_accept", (k < 50), 1);
    @(posedge clkb); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max, input bit tog);
    int  n = 0;
    bit  done = 1'b0;
    while (!done && n < max) begin
      @(posedge clkb); #1;
      if (tog) m_ready = !m_ready;
      n++;
      done = cmd_ready && (exp_beat_q.size() == 0);
    end
    chk("idle_reached", done, 1);
    m_ready = 1'b1;
  endtask

  // {ram_enb, ram_addrb, m_valid, m_last, cmd_ready, busy} for cycles T+1..T+7 of addr=5 len=3
  logic [10:0] t1 [7];
  int eb, bb, lb;

  initial begin
    t1 = '{11'b1_000101_0001, 11'b1_000110_0001, 11'b1_000111_0001,
           11'b0_001000_1001, 11'b0_001000_1001, 11'b0_001000_1101,
           11'b0_001000_0010};
    rstb_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b1;
    repeat (2) @(negedge clkb);
    chk("reset_outputs", {cmd_ready, ram_enb, ram_addrb, ram_regceb, m_valid, m_last, m_data, busy},
        {1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0});
    @(posedge clkb); #1 rstb_n = 1'b1;
    @(negedge clkb);
    chk("ready_before_edge", cmd_ready, 0);
    @(negedge clkb);
    chk("ready_after_release", cmd_ready, 1);

    // len=3 cycle-exact timing
    @(posedge clkb); #1;
    send_cmd(6'd5, 3);
    for (int k = 0; k < 7; k++) begin
      @(negedge clkb);
      chk($sformatf("t1_cycle%0d", k + 1), {ram_enb, ram_addrb, m_valid, m_last, cmd_ready, busy}, t1[k]);
    end

    // address wrap 62,63,0,1
    send_cmd(6'd62, 4);
    wait_idle(60, 1'b0);

    // credit limit with m_ready low, then full drain of 64 beats
    m_ready = 1'b0;
    eb = enb_cnt; bb = beat_cnt; lb = last_cnt;
    send_cmd(6'd10, 64);
    repeat (10) @(posedge clkb);
    @(negedge clkb);
    chk("credit_enb_count", enb_cnt - eb, 4);
    chk("credit_enb_low", ram_enb, 0);
    chk("credit_head", {m_valid, m_data}, {1'b1, 32'hBEEF_000A});
    @(posedge clkb); #1 m_ready = 1'b1;
    wait_idle(300, 1'b0);
    chk("len64_beats", beat_cnt - bb, 64);
    chk("len64_lasts", last_cnt - lb, 1);

    // ready toggling 1,0,1,0 over a 16-beat burst
    send_cmd(6'd40, 16);
    wait_idle(200, 1'b1);

    // zero-length command
    eb = enb_cnt; bb = beat_cnt;
    send_cmd(6'd7, 0);
    @(negedge clkb);
    chk("len0_outputs", {ram_enb, m_valid, cmd_ready, busy}, 4'b0010);
    repeat (3) @(negedge clkb);
    chk("len0_no_enb", enb_cnt - eb, 0);
    chk("len0_no_beat", beat_cnt - bb, 0);

    // reset mid-burst, then a clean short command
    send_cmd(6'd20, 10);
    repeat (5) @(posedge clkb);
    #1 rstb_n = 1'b0;
    exp_addr_q.delete();
    exp_beat_q.delete();
    #1;
    chk("midrst_outputs", {cmd_ready, ram_enb, ram_addrb, ram_regceb, m_valid, m_last, m_data, busy},
        {1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0});
    @(posedge clkb); #1 rstb_n = 1'b1;
    @(posedge clkb); #1;
    bb = beat_cnt; lb = last_cnt;
    send_cmd(6'd0, 2);
    wait_idle(60, 1'b0);
    repeat (5) @(negedge clkb);
    chk("post_rst_beats", beat_cnt - bb, 2);
    chk("post_rst_lasts", last_cnt - lb, 1);

    chk("addr_queue_empty", exp_addr_q.size(), 0);
    chk("beat_queue_empty", exp_beat_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
